sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Parametrised rectangle blitter that drives the vga_adapter plot interface (x, y, colour, plot).
- Sprite mode copies a SPR_W x SPR_H image from a synchronous colour ROM to screen origin (x0, y0).
- Fill mode paints a w x h rectangle in a single colour. Used to erase or clear regions.
- Sits between the animation control FSM and vga_adapter. Handles ROM read latency and clips pixels at the screen edge.

Parameters:
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOUR_W, 3, colour width
- ADDR_W, 14, ROM address width
- SPR_W, 80, sprite width in pixels
- SPR_H, 120, sprite height in pixels
- ROM_LAT, 1, ROM read latency in cycles (1..3)
- SCREEN_W, 320, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 240, visible height; pixels with y >= SCREEN_H are clipped

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- fill  in  1  mode select, latched at start: 0 = sprite, 1 = fill
- x0  in  X_W  origin x, latched at start
- y0  in  Y_W  origin y, latched at start
- w  in  X_W  fill width, latched at start; ignored in sprite mode
- h  in  Y_W  fill height, latched at start; ignored in sprite mode
- fill_colour  in  COLOUR_W  fill colour, latched at start
- rom_addr  out  ADDR_W  sprite ROM address
- rom_data  in  COLOUR_W  ROM data, valid ROM_LAT cycles after rom_addr
- vga_x  out  X_W  plot x
- vga_y  out  Y_W  plot y
- vga_colour  out  COLOUR_W  plot colour
- vga_plot  out  1  plot strobe
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, pipeline valid bits are cleared. Reset mid-operation aborts immediately; no further plots are issued.
- States:
  - IDLE: on start, latch the inputs and go to SCAN. If the effective W or H is 0, go to DONE instead.
  - SCAN: issue one pixel per cycle in raster order, col 0..W-1 within row 0..H-1. After the last pixel, go to DRAIN.
  - DRAIN: wait ROM_LAT cycles for the pipeline to empty, then go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- Effective size: W = SPR_W and H = SPR_H in sprite mode; W = w and H = h in fill mode.
- rom_addr = row*SPR_W + col, implemented as an incrementing counter starting at 0 (no multiplier). It is held at 0 in fill mode and in IDLE.
- Pipeline:
  - Pixel coordinates, the in-bounds flag and the valid bit are delayed ROM_LAT stages, so each plot aligns with its rom_data.
  - Fill mode uses the same pipeline, so timing is identical in both modes.
  - vga_colour = fill ? fill_colour : rom_data.
- Arithmetic: x0+col is computed at X_W+1 bits and y0+row at Y_W+1 bits.
  - A pixel is in-bounds iff x < SCREEN_W and y < SCREEN_H.
  - Out-of-bounds pixels still consume a cycle and a ROM address, but vga_plot stays 0.
  - vga_x and vga_y are the low X_W and Y_W bits.
- Timing, for start accepted at cycle 0:
  - busy = 1 from cycle 1 through the done cycle inclusive.
  - Pixel (0,0) address is issued at cycle 1; its plot appears at cycle 1+ROM_LAT.
  - Last plot appears at cycle W*H+ROM_LAT; done pulses at cycle W*H+ROM_LAT+1.
- Zero-size request: done pulses at cycle 1, busy is high for that cycle only, no plots.
- start while busy, or in DONE, is ignored. start in the same cycle as reset is ignored.
- Latched inputs may change during busy without effect.

Optional Feature:
- Macro: SPRITE_BLITTER_TRANSPARENCY_EN.
- When defined:
  - Adds parameter KEY_COLOUR (default 3'b000) and input port key_en (1 bit, latched at start).
  - In sprite mode with key_en = 1, pixels whose rom_data == KEY_COLOUR are not plotted (vga_plot = 0).
  - Cycle timing and done timing are unchanged.
  - Fill mode is unaffected.
- When undefined: no key_en port, and every in-bounds pixel is plotted.

Test Plan:
- Sprite copy, SPR_W=4, SPR_H=2, ROM_LAT=1, x0=10, y0=5, ROM content = address → 8 plots at (10..13, 5..6), colour 0..7 in raster order. First plot at cycle 2, done at cycle 10, busy high cycles 1-10.
- Fill, w=3, h=2, fill_colour=3'b101, x0=0, y0=0 → plots (0..2, 0..1), all colour 5. rom_addr stays 0. done at cycle 8.
- Clipping, fill x0=318, y0=239, w=4, h=2 → only (318,239) and (319,239) plotted. done still at cycle 4*2+1+1 = 10.
- Zero size, fill w=0, h=5 → no vga_plot, done at cycle 1. A second start pulsed during busy of a normal job → ignored, exactly one done.
- Reset asserted at cycle 4 of a sprite copy → from cycle 5: vga_plot = 0, busy = 0, done never pulses. A new start afterwards completes normally.
- ROM_LAT=3: each plot's colour matches the ROM word for its address. With SPRITE_BLITTER_TRANSPARENCY_EN and key_en=1, ROM words equal to 0 produce no plot and done timing is unchanged.

Source files
------------

// File: rtl/sprite_blitter.sv
// Rectangle blitter: copies a sprite from a synchronous ROM, or paints a solid fill, onto the VGA plot port.
// Optional colour-key transparency is enabled by defining SPRITE_BLITTER_TRANSPARENCY_EN.
module sprite_blitter #(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned SPR_W    = 80,
  parameter int unsigned SPR_H    = 120,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  ,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                fill,
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  input  logic                key_en,
`endif
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  localparam int unsigned Last = ROM_LAT - 1;
  localparam logic [X_W:0] ScrW = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] ScrH = SCREEN_H[Y_W:0];

  state_e              state_q;
  logic                fill_q;
  logic [X_W-1:0]      x0_q, w_q, col_q;
  logic [Y_W-1:0]      y0_q, h_q, row_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          lat_cnt_q;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  logic                key_q;
`endif

  logic [X_W-1:0] w_eff;
  logic [Y_W-1:0] h_eff;
  logic           last_col, last_row;
  logic [X_W:0]   px_sum;
  logic [Y_W:0]   py_sum;
  logic           in_bounds;

  assign w_eff     = fill ? w : X_W'(SPR_W);
  assign h_eff     = fill ? h : Y_W'(SPR_H);
  assign last_col  = (col_q == w_q - X_W'(1));
  assign last_row  = (row_q == h_q - Y_W'(1));
  assign px_sum    = {1'b0, x0_q} + {1'b0, col_q};
  assign py_sum    = {1'b0, y0_q} + {1'b0, row_q};
  assign in_bounds = (px_sum < ScrW) && (py_sum < ScrH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      fill_q    <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      lat_cnt_q <= '0;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
      key_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            fill_q   <= fill;
            x0_q     <= x0;
            y0_q     <= y0;
            w_q      <= w_eff;
            h_q      <= h_eff;
            colour_q <= fill_colour;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
            key_q    <= key_en;
`endif
            state_q  <= (w_eff == '0 || h_eff == '0) ? StDone : StScan;
          end
        end
        StScan: begin
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + Y_W'(1);
          end else begin
            col_q <= col_q + X_W'(1);
          end
          if (!fill_q) addr_q <= addr_q + ADDR_W'(1);
          if (last_col && last_row) begin
            addr_q    <= '0;
            lat_cnt_q <= '0;
            state_q   <= StDrain;
          end
        end
        StDrain: begin
          if (lat_cnt_q == 2'(ROM_LAT - 1)) state_q <= StDone;
          else lat_cnt_q <= lat_cnt_q + 2'd1;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Coordinate/valid pipeline matched to the ROM read latency.
  logic [ROM_LAT-1:0] vld_q, inb_q;
  logic [X_W-1:0]     px_q [ROM_LAT];
  logic [Y_W-1:0]     py_q [ROM_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      inb_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= (state_q == StScan);
      inb_q[0] <= in_bounds;
      px_q[0]  <= px_sum[X_W-1:0];
      py_q[0]  <= py_sum[Y_W-1:0];
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        inb_q[i] <= inb_q[i-1];
        px_q[i]  <= px_q[i-1];
        py_q[i]  <= py_q[i-1];
      end
    end
  end

  logic keep;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign keep = !(key_q && !fill_q && (rom_data == KEY_COLOUR));
`else
  assign keep = 1'b1;
`endif

  assign rom_addr   = addr_q;
  assign vga_x      = px_q[Last];
  assign vga_y      = py_q[Last];
  assign vga_colour = vld_q[Last] ? (fill_q ? colour_q : rom_data) : '0;
  assign vga_plot   = vld_q[Last] & inb_q[Last] & keep;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: two instances (ROM latency 1 and 3) driven in lockstep.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       reset, start, fill;
  logic [8:0] x0, w;
  logic [7:0] y0, h;
  logic [2:0] fill_colour;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  logic       key_en;
`endif

  logic [13:0] addr1, addr3;
  logic [8:0]  x1, x3;
  logic [7:0]  y1, y3;
  logic [2:0]  c1, c3;
  logic        plot1, plot3, busy1, busy3, done1, done3;
  logic [2:0]  rom1_q;
  logic [2:0]  rom3_q [3];

  always #5 clk = ~clk;

  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ROM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset), .start(start), .fill(fill),
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    .key_en(key_en),
`endif
    .x0(x0), .y0(y0), .w(w), .h(h), .fill_colour(fill_colour),
    .rom_addr(addr1), .rom_data(rom1_q),
    .vga_x(x1), .vga_y(y1), .vga_colour(c1), .vga_plot(plot1),
    .busy(busy1), .done(done1)
  );

  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ROM_LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset), .start(start), .fill(fill),
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    .key_en(key_en),
`endif
    .x0(x0), .y0(y0), .w(w), .h(h), .fill_colour(fill_colour),
    .rom_addr(addr3), .rom_data(rom3_q[2]),
    .vga_x(x3), .vga_y(y3), .vga_colour(c3), .vga_plot(plot3),
    .busy(busy3), .done(done3)
  );

  // ROM contents differ per instance so colour alignment is checked independently.
  function automatic logic [2:0] rom_word(input int d, input int a);
    logic [2:0] v;
    v = 3'(a);
    return (d == 0) ? v : (v ^ 3'b101);
  endfunction

  always @(posedge clk) begin
    rom1_q    <= rom_word(0, int'(addr1));
    rom3_q[0] <= rom_word(1, int'(addr3));
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int x; int y; int c;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   done_exp [2] = '{-1, -1};
  int   bl [2] = '{1, 1};
  int   bh [2] = '{0, 0};
  int   sl = 1, sh = 0;
  bit   job_fill = 1'b0;
  bit   mon_en = 1'b0;
  int   n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic plot, input logic [8:0] x, input logic [7:0] y,
                     input logic [2:0] c, input logic dn, input logic bsy, input logic [13:0] ad);
    string p;
    exp_t  e;
    bit    have;
    p = (d == 0) ? "lat1_" : "lat3_";
    have = 1'b0;
    if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
    if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
    check_eq({p, "busy"}, 32'(bsy), 32'(cyc >= bl[d] && cyc <= bh[d]));
    if (cyc >= sl && cyc <= sh) check_eq({p, "rom_addr"}, 32'(ad), job_fill ? 0 : cyc - sl);
    if (plot || (have && e.cyc <= cyc)) begin
      check_eq({p, "plot_expected"}, 32'(have), 1);
      check_eq({p, "plot_strobe"}, 32'(plot), 1);
      if (have) begin
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        if (plot) begin
          check_eq({p, "plot_cycle"}, cyc, e.cyc);
          check_eq({p, "plot_x"}, 32'(x), e.x);
          check_eq({p, "plot_y"}, 32'(y), e.y);
          check_eq({p, "plot_colour"}, 32'(c), e.c);
        end
      end
    end
    if (dn) begin
      check_eq({p, "done_cycle"}, cyc, done_exp[d]);
      done_exp[d] = -1;
    end else if (done_exp[d] >= 0 && cyc >= done_exp[d]) begin
      check_eq({p, "done_pulse"}, 32'(dn), 1);
      done_exp[d] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, plot1, x1, y1, c1, done1, busy1, addr1);
      mon(1, plot3, x3, y3, c3, done3, busy3, addr3);
    end
  end

  task automatic launch(input bit f, input int xv, input int yv, input int wv, input int hv,
                        input int colv, input bit key);
    int   c0, ww, hh, lat, xx, yy, cc;
    exp_t e;
    @(posedge clk); #1;
    fill = f; x0 = 9'(xv); y0 = 8'(yv); w = 9'(wv); h = 8'(hv); fill_colour = 3'(colv);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    key_en = key;
`endif
    start = 1'b1;
    c0 = cyc;
    ww = f ? wv : 4;
    hh = f ? hv : 2;
    job_fill = f;
    sl = c0 + 1;
    sh = c0 + ww * hh;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      bl[d] = c0 + 1;
      bh[d] = (ww * hh == 0) ? c0 + 1 : c0 + ww * hh + lat + 1;
      done_exp[d] = bh[d];
      for (int i = 0; i < ww * hh; i++) begin
        xx = xv + i % ww;
        yy = yv + i / ww;
        cc = f ? colv : int'(rom_word(d, i));
        if (xx < 320 && yy < 240 && !(key && !f && cc == 0)) begin
          e = '{cyc: c0 + 1 + i + lat, x: xx, y: yy, c: cc};
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((done_exp[0] >= 0 || done_exp[1] >= 0 || q0.size() != 0 || q1.size() != 0)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("job_timeout", 32'(n >= budget), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    reset = 1'b1; start = 1'b0; fill = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; fill_colour = '0;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    key_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_x",      32'(x1 | x3), 0);
    check_eq("rst_y",      32'(y1 | y3), 0);
    check_eq("rst_colour", 32'(c1 | c3), 0);
    check_eq("rst_plot",   32'(plot1 | plot3), 0);
    check_eq("rst_busy",   32'(busy1 | busy3), 0);
    check_eq("rst_done",   32'(done1 | done3), 0);
    check_eq("rst_addr",   32'(addr1 | addr3), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    launch(1'b0, 10, 5, 0, 0, 0, 1'b0);       // sprite copy
    wait_idle(100);
    launch(1'b1, 0, 0, 3, 2, 5, 1'b0);        // fill
    wait_idle(100);
    launch(1'b1, 318, 239, 4, 2, 6, 1'b0);    // fill clipped at bottom-right
    wait_idle(100);
    launch(1'b1, 40, 40, 0, 5, 1, 1'b0);      // zero width
    wait_idle(100);

    // Start pulse mid-job with different inputs must be ignored.
    launch(1'b1, 20, 30, 3, 3, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; fill = 1'b0; x0 = 9'd99; y0 = 8'd1; w = 9'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100);

    // Reset during cycle 4 of a sprite copy, with a start that must be ignored.
    launch(1'b0, 100, 100, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    lim = cyc;
    while (q0.size() > 0 && q0[$].cyc > lim) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].cyc > lim) void'(q1.pop_back());
    for (int d = 0; d < 2; d++) begin
      bh[d] = lim;
      done_exp[d] = -1;
    end
    if (sh > lim) sh = lim;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (4) @(posedge clk);

    launch(1'b0, 318, 239, 0, 0, 0, 1'b0);    // sprite after reset, clipped
    wait_idle(100);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    launch(1'b0, 50, 60, 0, 0, 0, 1'b1);      // keyed sprite
    wait_idle(100);
    key_en = 1'b0;
`endif

    check_eq("leftover_plots", 32'(q0.size() + q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
